// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter with a small word FIFO in front of it. Words accepted on a
// valid/ready push interface are buffered, then serialised LSB first as
// start bit, DATA_BITS payload bits, an optional parity bit and one or two
// stop bits. When one frame's last stop bit ends and another word is waiting,
// the next start bit follows at once and busy stays high in between.
//
// The baud divisor, parity mode and stop-bit count are sampled when a word is
// popped. Changing them mid-frame only affects the next frame.
//
// Parameters
//   DATA_BITS   payload bits per frame (5..9)
//   FIFO_DEPTH  buffered words (power of two, >= 2)
//   DIV_WIDTH   width of the baud divisor
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   tx_data      word to transmit, LSB first
//   tx_valid     producer has a word on tx_data
//   tx_ready     FIFO has room (fifo_count < FIFO_DEPTH)
//   baud_div     clock cycles per serial bit (values below 2 act as 2)
//   parity_mode  00 none, 01 even, 10 odd, 11 none
//   stop2        0: one stop bit, 1: two stop bits
//   TxD          serial line, idle high
//   busy         high while a frame is on the line
//   fifo_count   words currently buffered
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  input  logic [DIV_WIDTH-1:0]               baud_div,
  input  logic [1:0]                         parity_mode,
  input  logic                               stop2,
  output logic                               TxD,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] ONE_DIV  = DIV_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // ------------------------------------------------------------------------
  // FIFO
  // ------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head;

  assign tx_ready   = (count_q < FULL_CNT);
  assign fifo_count = count_q;
  assign fifo_empty = (count_q == '0);
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr_q];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count_q, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
  end

  // ------------------------------------------------------------------------
  // Transmit FSM
  // ------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 bit_end;

  // div_q is never below 2 once a frame is running, so div_q-1 cannot wrap.
  assign bit_end = (baud_cnt_q == div_q - ONE_DIV);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    pop        = 1'b0;

    if (state_q != IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + ONE_DIV;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = par_en_q ? PARITY : STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          // bit_cnt_q counts stop bits already completed.
          if (!stop2_q || bit_cnt_q != '0) begin
            if (!fifo_empty) pop = 1'b1;
            else             state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop loads the next word and snapshots the line configuration.
    if (pop) begin
      state_d    = START;
      shift_d    = head;
      div_d      = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
      par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d  = (^head) ^ parity_mode[1];
      stop2_d    = stop2;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end

    // Line level and busy follow the next state so both are registered.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_bit_d;
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      div_q      <= MIN_DIV;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  assign TxD  = txd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo (DATA_BITS=8, FIFO_DEPTH=4).
// A behavioural model holds a queue of pending words and a queue of the line
// levels still to be driven, one entry per clock cycle. Every cycle the DUT's
// TxD, busy, fifo_count and tx_ready are compared with the model. Literal
// expectations for frame lengths, frame bit patterns and the reset behaviour
// pin the model itself.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_WIDTH  = 16;

  logic        clk         = 1'b0;
  logic        reset       = 1'b0;
  logic [7:0]  tx_data     = '0;
  logic        tx_valid    = 1'b0;
  logic        tx_ready;
  logic [15:0] baud_div    = 16'd4;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop2       = 1'b0;
  logic        TxD;
  logic        busy;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [7:0] m_fifo [$];
  bit         m_line [$];

  uart_tx_fifo #(
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .baud_div   (baud_div),
    .parity_mode(parity_mode),
    .stop2      (stop2),
    .TxD        (TxD),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic build_frame(input logic [7:0] w);
    int div;
    bit seq [$];
    div = (baud_div < 16'd2) ? 2 : int'(baud_div);
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) seq.push_back(w[i]);
    if (parity_mode == 2'b01)      seq.push_back(^w);
    else if (parity_mode == 2'b10) seq.push_back(~^w);
    seq.push_back(1'b1);
    if (stop2) seq.push_back(1'b1);
    foreach (seq[k]) repeat (div) m_line.push_back(seq[k]);
  endtask

  task automatic model_step();
    bit do_push;
    do_push = tx_valid && (m_fifo.size() < FIFO_DEPTH);
    if (m_line.size() > 0) void'(m_line.pop_front());
    if (m_line.size() == 0 && m_fifo.size() > 0) build_frame(m_fifo.pop_front());
    if (do_push) m_fifo.push_back(tx_data);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_line.delete();
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("txd",        TxD,        (m_line.size() > 0) ? m_line[0] : 1'b1);
      check("busy",       busy,       m_line.size() > 0);
      check("fifo_count", fifo_count, m_fifo.size());
      check("tx_ready",   tx_ready,   m_fifo.size() < FIFO_DEPTH);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input logic [7:0] d);
    int guard;
    guard    = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (m_fifo.size() >= FIFO_DEPTH && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("push_timeout", guard, 0);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Waits for busy, then records one busy run: its length, the line level at
  // the first cycle of each bit period, and the largest fifo_count seen.
  task automatic capture(input int div, output int len, output logic [31:0] bits,
                         output int max_cnt);
    int waited;
    waited  = 0;
    len     = 0;
    bits    = '0;
    max_cnt = 0;
    while (busy !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (busy !== 1'b1) begin
      check("frame_start", busy, 1);
      return;
    end
    while (busy === 1'b1 && len < 400) begin
      if (len % div == 0 && len / div < 32) bits[len / div] = TxD;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      len++;
      @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          len;
    int          mc;
    int          busy_seen;
    logic [31:0] bits;

    #1 reset = 1'b1;
    #2;
    check("init_txd",   TxD,        1);
    check("init_busy",  busy,       0);
    check("init_count", fifo_count, 0);
    check("init_ready", tx_ready,   1);
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // 8N1, divisor 4
    baud_div = 16'd4; parity_mode = 2'b00; stop2 = 1'b0;
    push(8'hA5);
    capture(4, len, bits, mc);
    check("8n1_len",  len,  40);
    check("8n1_bits", bits, 32'({1'b1, 8'hA5, 1'b0}));

    // 8E1, divisor 3: 0x07 has three ones, even parity bit 1
    baud_div = 16'd3; parity_mode = 2'b01; stop2 = 1'b0;
    push(8'h07);
    capture(3, len, bits, mc);
    check("8e1_len",  len,  33);
    check("8e1_bits", bits, 32'({1'b1, 1'b1, 8'h07, 1'b0}));

    // 8O2, divisor 3: odd parity bit 0, two stop bits
    parity_mode = 2'b10; stop2 = 1'b1;
    push(8'h07);
    capture(3, len, bits, mc);
    check("8o2_len",  len,  36);
    check("8o2_bits", bits, 32'({2'b11, 1'b0, 8'h07, 1'b0}));

    // Divisors 0 and 1 behave as 2
    parity_mode = 2'b00; stop2 = 1'b0; baud_div = 16'd0;
    push(8'h55);
    capture(2, len, bits, mc);
    check("div0_len",  len,  20);
    check("div0_bits", bits, 32'({1'b1, 8'h55, 1'b0}));
    baud_div = 16'd1;
    push(8'hC3);
    capture(2, len, bits, mc);
    check("div1_len",  len,  20);
    check("div1_bits", bits, 32'({1'b1, 8'hC3, 1'b0}));

    // FIFO: six words with valid held; frames back to back, FIFO fills to 4
    baud_div = 16'd2;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [7:0] w;
          w = 8'(17 * (i + 1));
          push(w);
        end
      end
      capture(2, len, bits, mc);
    join
    check("fifo_run_len",   len, 120);
    check("fifo_max_count", mc,  FIFO_DEPTH);
    check("fifo_first",     bits[9:0], 32'({1'b1, 8'h11, 1'b0}));

    // Parity enabled mid-frame: first frame none, second frame even parity
    baud_div = 16'd2; parity_mode = 2'b00;
    fork
      begin
        push(8'h3C);
        push(8'h5A);
        repeat (6) @(negedge clk);
        parity_mode = 2'b01;
      end
      capture(2, len, bits, mc);
    join
    check("cfg_run_len", len, 42);
    check("cfg_bits", bits,
          32'({1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h3C, 1'b0}));

    // Reset mid-frame with three words queued
    parity_mode = 2'b00; baud_div = 16'd4;
    for (int i = 0; i < 4; i++) push(8'(8'hF0 + i));
    check("pre_rst_count", fifo_count, 3);
    repeat (10) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_txd",   TxD,        1);
    check("rst_busy",  busy,       0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", tx_ready,   1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    busy_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    check("post_rst_idle", busy_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
